// File: rtl/disp_hex_mux.sv
// Four-digit time-multiplexed hex display scanner with tear-free frame shadowing
// and leading-zero blanking; outputs are decoded purely from registered state.
module disp_hex_mux #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] hex_val,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [3:0]  hex,
    output logic        dp_n
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_val_q, shadow_val_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [3:0]    blank_q, blank_d;
    logic          en_q, en_d;

    logic          tick, wrap;
    logic [3:0]    nz;
    logic [3:0]    nib;
    logic          lit;

    // Per-digit "has content" flags from the incoming frame, used to build the blank mask.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            nz[k] = (|hex_val[4*k +: 4]) | dp_in[k];
        end
    end

    always_comb begin
        tick         = en && (cnt_q == CNT_MAX);
        wrap         = tick && (idx_q == 2'd3);
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        blank_d      = blank_q;
        en_d         = en;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) idx_d = idx_q + 2'd1;
        end
        if (wrap) begin
            shadow_val_d = hex_val;
            shadow_dp_d  = dp_in;
            blank_d[3]   = lz_en && !nz[3];
            blank_d[2]   = lz_en && !nz[3] && !nz[2];
            blank_d[1]   = lz_en && !nz[3] && !nz[2] && !nz[1];
            blank_d[0]   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'b0000;
            blank_q      <= 4'b0000;
            en_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            blank_q      <= blank_d;
            en_q         <= en_d;
        end
    end

    always_comb begin
        nib  = shadow_val_q[{idx_q, 2'b00} +: 4];
        lit  = en_q && !blank_q[idx_q];
        an   = lit ? ~(4'b0001 << idx_q) : 4'b1111;
        hex  = lit ? nib : 4'h0;
        dp_n = lit ? ~shadow_dp_q[idx_q] : 1'b1;
    end
endmodule

// File: tb/tb_disp_hex_mux.sv
// Directed bench for disp_hex_mux with REFRESH_DIV=4: scan order, tear-free
// update, blanking, dp override, enable freeze/resume and mid-frame reset.
module tb_disp_hex_mux;
    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] hex_val;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [3:0]  hex;
    logic        dp_n;

    int vectors;
    int miscompares;

    disp_hex_mux #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .hex_val(hex_val), .dp_in(dp_in),
        .lz_en(lz_en), .an(an), .hex(hex), .dp_n(dp_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n cycles, checking outputs 1 time unit after each rising edge.
    task automatic slot(input string tag, input logic [3:0] a, input logic [3:0] h,
                        input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vectors++;
            assert ({an, hex, dp_n} === {a, h, d}) else begin
                miscompares++;
                $error("FAIL %s cyc %0d: got an=%b hex=%h dp_n=%b, want an=%b hex=%h dp_n=%b",
                       tag, i, an, hex, dp_n, a, h, d);
            end
            vectors++;
            assert ($countones(~an) <= 1) else begin
                miscompares++;
                $error("FAIL %s_onehot cyc %0d: got an=%b, want at most one low bit", tag, i, an);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; en = 1'b1; hex_val = 16'h1A2F; dp_in = 4'b0000; lz_en = 1'b0;

        slot("reset", 4'b1111, 4'h0, 1'b1, 2);
        rst = 1'b0;

        // First frame shows the cleared shadow; digit 0 lasts 3 cycles since en_q starts at 0.
        slot("pre_d0", 4'b1110, 4'h0, 1'b1, 3);
        slot("pre_d1", 4'b1101, 4'h0, 1'b1, 4);
        slot("pre_d2", 4'b1011, 4'h0, 1'b1, 4);
        slot("pre_d3", 4'b0111, 4'h0, 1'b1, 4);
        slot("scan_d0", 4'b1110, 4'hF, 1'b1, 4);
        slot("scan_d1", 4'b1101, 4'h2, 1'b1, 4);
        slot("scan_d2", 4'b1011, 4'hA, 1'b1, 4);
        slot("scan_d3", 4'b0111, 4'h1, 1'b1, 4);

        // Tear-free update: change input while digit 1 is active.
        hex_val = 16'h1234;
        slot("tf_d0", 4'b1110, 4'h4, 1'b1, 4);
        slot("tf_d1a", 4'b1101, 4'h3, 1'b1, 1);
        hex_val = 16'h5678;
        slot("tf_d1b", 4'b1101, 4'h3, 1'b1, 3);
        slot("tf_d2", 4'b1011, 4'h2, 1'b1, 4);
        slot("tf_d3", 4'b0111, 4'h1, 1'b1, 4);
        slot("new_d0", 4'b1110, 4'h8, 1'b1, 4);
        slot("new_d1", 4'b1101, 4'h7, 1'b1, 4);
        slot("new_d2", 4'b1011, 4'h6, 1'b1, 4);
        slot("new_d3", 4'b0111, 4'h5, 1'b1, 4);

        // Leading-zero blanking.
        lz_en = 1'b1; hex_val = 16'h0030;
        slot("lz_d0", 4'b1110, 4'h0, 1'b1, 4);
        slot("lz_d1", 4'b1101, 4'h3, 1'b1, 4);
        slot("lz_d2", 4'b1111, 4'h0, 1'b1, 4);
        slot("lz_d3", 4'b1111, 4'h0, 1'b1, 4);
        hex_val = 16'h0000;
        slot("zero_d0", 4'b1110, 4'h0, 1'b1, 4);
        slot("zero_d123", 4'b1111, 4'h0, 1'b1, 12);

        // Decimal point on digit 2 stops blanking at digit 2.
        hex_val = 16'h0005; dp_in = 4'b0100;
        slot("dp_d0", 4'b1110, 4'h5, 1'b1, 4);
        slot("dp_d1", 4'b1101, 4'h0, 1'b1, 4);
        slot("dp_d2", 4'b1011, 4'h0, 1'b0, 4);
        slot("dp_d3", 4'b1111, 4'h0, 1'b1, 4);

        // Enable freeze mid-slot, then resume with the remaining slot count.
        lz_en = 1'b0; dp_in = 4'b0000; hex_val = 16'h1A2F;
        slot("en_d0a", 4'b1110, 4'hF, 1'b1, 2);
        en = 1'b0;
        slot("en_off", 4'b1111, 4'h0, 1'b1, 10);
        en = 1'b1;
        slot("en_d0b", 4'b1110, 4'hF, 1'b1, 2);
        slot("en_d1", 4'b1101, 4'h2, 1'b1, 4);

        // Reset mid-frame discards the frame and restarts at digit 0, prescaler 0.
        slot("mid_d2", 4'b1011, 4'hA, 1'b1, 2);
        rst = 1'b1;
        slot("mid_rst", 4'b1111, 4'h0, 1'b1, 1);
        rst = 1'b0;
        slot("rst_d0", 4'b1110, 4'h0, 1'b1, 3);
        slot("rst_d1", 4'b1101, 4'h0, 1'b1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/disp_hex_mux.md
DISP_HEX_MUX -- requirements
Module: disp_hex_mux

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (legal range 2..2^24).
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The module SHALL have port en, input, 1, display enable.
REQ-005 The module SHALL have port hex_val, input, 16, four hex digits; digit k is hex_val[4k+3:4k], digit 0 rightmost.
REQ-006 The module SHALL have port dp_in, input, 4, decimal point request per digit, bit k for digit k, active-high.
REQ-007 The module SHALL have port lz_en, input, 1, leading-zero blanking enable.
REQ-008 The module SHALL have port an, output, 4, digit anode enables, active-low, bit k for digit k.
REQ-009 The module SHALL have port hex, output, 4, nibble of the active digit, fed to the downstream hex-to-7-segment decoder.
REQ-010 The module SHALL have port dp_n, output, 1, decimal point segment, active-low.

Function
REQ-011 The module SHALL hold a prescaler counting 0..REFRESH_DIV-1; tick is asserted in the cycle the count equals REFRESH_DIV-1, and the count then wraps to 0.
REQ-012 The module SHALL hold a 2-bit digit index that increments on each tick and wraps 3->0.
REQ-013 The module SHALL hold a 16-bit shadow value and a 4-bit shadow dp register, loaded from hex_val/dp_in on the tick where the digit index wraps 3->0, so that a frame never mixes old and new values.
REQ-014 Outputs SHALL be decoded from registered state only (digit index, shadow registers, blank mask, en register), never from hex_val/dp_in directly, with no combinational path from inputs to outputs.
REQ-015 For an unblanked active digit k: an = all ones except bit k = 0; hex = shadow nibble k; dp_n = ~shadow_dp[k].
REQ-016 Digit k (k = 3,2,1) SHALL be blanked when lz_en = 1 and shadow nibbles 3..k are all zero and shadow_dp[3..k] are all zero; digit 0 is never blanked.
REQ-017 For a blanked active digit: an = 4'b1111, hex = 4'h0, dp_n = 1.
REQ-018 The module SHALL sample lz_en into the blank mask at the same frame boundary as the shadow load (REQ-013).
REQ-019 When en = 0, the prescaler and digit index SHALL freeze, and an = 4'b1111, hex = 4'h0, dp_n = 1 from the next cycle. The shadow load does not occur.
REQ-020 When en returns to 1, scanning SHALL resume from the frozen prescaler/digit values, and outputs follow REQ-015..017 from the next cycle.
REQ-021 At most one an bit SHALL be low in any cycle.

Reset
REQ-022 While rst = 1 at a clock edge, all of the following SHALL hold: prescaler = 0, digit index = 0, shadow value = 16'h0000, shadow dp = 4'b0000, blank mask cleared, en register = 0.
REQ-023 In the cycle after reset, outputs SHALL be an = 4'b1111, hex = 4'h0, dp_n = 1.
REQ-024 Reset SHALL take priority over en and tick, and reset mid-frame SHALL discard the partial frame and restart at digit 0.

Verification
REQ-025 Basic scan: REFRESH_DIV=4, en=1, lz_en=0, hex_val=16'h1A2F, dp_in=0. Required: after the first frame boundary, an cycles 1110,1101,1011,0111 every 4 clocks; hex shows F,2,A,1; dp_n=1 throughout.
REQ-026 Tear-free update: hex_val changes 16'h1234->16'h5678 while digit 1 is active. Required: the remainder of the frame shows 3,2,1 on digits 1..3, and 8,7,6,5 appears from the next digit-0 slot.
REQ-027 Leading-zero blanking: lz_en=1, hex_val=16'h0030. Required: digits 3,2 show an=1111; digit 1 shows hex=3; digit 0 shows hex=0. With hex_val=16'h0000, only digit 0 is lit, showing 0.
REQ-028 DP blocks blanking: lz_en=1, hex_val=16'h0005, dp_in=4'b0100. Required: digit 3 is blanked; digit 2 shows hex=0 with dp_n=0; digits 1 and 0 show 0 and 5.
REQ-029 Enable and reset: en=0 for 10 cycles mid-slot. Required: an=1111 throughout, then resume on the same digit with the remaining slot count. Asserting rst mid-frame gives an=1111 next cycle and, after release, restart at digit 0 with the prescaler at 0.
